// File: rtl/threshold_cfg_master_if.sv
// ---------------------------------------------------------------------------
// threshold_cfg_master_if
// Purpose : AXI4-Lite bundle between the threshold configuration master and
//           the register slave it programs.
// Signals : aw{addr,prot,valid,ready}  write address channel
//           w{data,strb,valid,ready}   write data channel
//           b{resp,valid,ready}        write response channel
//           ar{addr,prot,valid,ready}  read address channel
//           r{data,resp,valid,ready}   read data channel
// Modports: master drives valids/payloads and the b/r readies,
//           slave is the mirror image.
// ---------------------------------------------------------------------------
interface threshold_cfg_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/threshold_cfg_master.sv
// ---------------------------------------------------------------------------
// threshold_cfg_master
// Purpose : On a start pulse, writes four 32-bit threshold registers over
//           AXI4-Lite, reads each one back and compares it with the value
//           written. Reports completion, and on the first failure the index
//           and cause (bad BRESP, bad RRESP/data, or handshake timeout).
// Ports   : m00_axi_aclk    clock, rising edge
//           m00_axi_areset  asynchronous active-high reset
//           start           single-cycle request, honoured only when idle
//           cfg_data        four register values, word i at [32i+31:32i]
//           busy            high whenever the sequence is not idle
//           done            one-cycle pulse at the end of every sequence
//           error           sticky failure flag, cleared by the next start
//           err_index       register index at which the failure occurred
//           err_code        0 none, 1 BRESP, 2 RRESP/data, 3 timeout
//           m00_axi         AXI4-Lite master port (interface)
// ---------------------------------------------------------------------------
module threshold_cfg_master #(
  parameter int C_M00_AXI_ADDR_WIDTH = 32,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter logic [C_M00_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR =
    C_M00_AXI_ADDR_WIDTH'(32'h43C0_0000),
  parameter int C_TIMEOUT = 1024
) (
  input  logic                  m00_axi_aclk,
  input  logic                  m00_axi_areset,
  input  logic                  start,
  input  logic [127:0]          cfg_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_index,
  output logic [1:0]            err_code,
  threshold_cfg_master_if.master m00_axi
);

  localparam int LP_CNT_W = $clog2(C_TIMEOUT + 1);
  localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(C_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WAIT_B, S_RD, S_WAIT_R, S_CHECK, S_DONE
  } state_t;

  state_t                            r_state;
  logic [1:0]                        r_idx;
  logic [LP_CNT_W-1:0]               r_cnt;
  logic [127:0]                      r_cfg;
  logic [C_M00_AXI_DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]                        r_rresp;
  logic [C_M00_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [C_M00_AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic [31:0]                       r_wdata;
  logic                              r_awvalid;
  logic                              r_wvalid;
  logic                              r_bready;
  logic                              r_arvalid;
  logic                              r_rready;

  logic w_awDone;
  logic w_wDone;
  logic w_timeout;

  // Register address for index i; the sum wraps naturally at the bus width.
  function automatic logic [C_M00_AXI_ADDR_WIDTH-1:0] addrOf(input logic [1:0] i);
    return C_BASE_ADDR + C_M00_AXI_ADDR_WIDTH'({i, 2'b00});
  endfunction

  // Configuration word for index i out of the latched 128-bit vector.
  function automatic logic [31:0] wordOf(input logic [127:0] cfg, input logic [1:0] i);
    return cfg[{i, 5'b00000} +: 32];
  endfunction

  // Bus outputs are driven straight from registers; protection is always
  // unprivileged/secure/data and every write covers all four byte lanes.
  assign m00_axi.awaddr  = r_awaddr;
  assign m00_axi.awprot  = 3'b000;
  assign m00_axi.awvalid = r_awvalid;
  assign m00_axi.wdata   = r_wdata;
  assign m00_axi.wstrb   = '1;
  assign m00_axi.wvalid  = r_wvalid;
  assign m00_axi.bready  = r_bready;
  assign m00_axi.araddr  = r_araddr;
  assign m00_axi.arprot  = 3'b000;
  assign m00_axi.arvalid = r_arvalid;
  assign m00_axi.rready  = r_rready;

  // A write channel counts as finished once its valid has already dropped
  // or it is being accepted this cycle, so AW and W may complete in any
  // order. The timeout fires only when the waiting state makes no progress
  // in the cycle the counter reaches its last value.
  assign w_awDone  = ~r_awvalid | m00_axi.awready;
  assign w_wDone   = ~r_wvalid | m00_axi.wready;
  assign w_timeout = (r_cnt == LP_CNT_LAST) &&
                     (((r_state == S_WR) && !(w_awDone && w_wDone)) ||
                      ((r_state == S_WAIT_B) && !m00_axi.bvalid) ||
                      ((r_state == S_RD) && !m00_axi.arready) ||
                      ((r_state == S_WAIT_R) && !m00_axi.rvalid));

  // Sequencer: write register idx, wait for its response, read it back,
  // compare, then advance to the next index. All outputs are registered and
  // set on the transition into the state that needs them. The timeout block
  // at the bottom overrides whatever the state case decided that cycle.
  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      r_state   <= S_IDLE;
      r_idx     <= 2'd0;
      r_cnt     <= '0;
      r_cfg     <= '0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= 2'd0;
      err_code  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cfg     <= cfg_data;
            error     <= 1'b0;
            err_index <= 2'd0;
            err_code  <= 2'd0;
            r_idx     <= 2'd0;
            r_cnt     <= '0;
            busy      <= 1'b1;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= addrOf(2'd0);
            r_wdata   <= wordOf(cfg_data, 2'd0);
            r_state   <= S_WR;
          end
        end
        S_WR: begin
          if (m00_axi.awready) r_awvalid <= 1'b0;
          if (m00_axi.wready) r_wvalid <= 1'b0;
          if (w_awDone && w_wDone) begin
            r_bready <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_WAIT_B;
          end else begin
            r_cnt <= r_cnt + LP_CNT_W'(1);
          end
        end
        S_WAIT_B: begin
          if (m00_axi.bvalid) begin
            r_bready <= 1'b0;
            r_cnt    <= '0;
            if (m00_axi.bresp != 2'b00) begin
              error     <= 1'b1;
              err_code  <= 2'd1;
              err_index <= r_idx;
              done      <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_arvalid <= 1'b1;
              r_araddr  <= addrOf(r_idx);
              r_state   <= S_RD;
            end
          end else begin
            r_cnt <= r_cnt + LP_CNT_W'(1);
          end
        end
        S_RD: begin
          if (m00_axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_WAIT_R;
          end else begin
            r_cnt <= r_cnt + LP_CNT_W'(1);
          end
        end
        S_WAIT_R: begin
          if (m00_axi.rvalid) begin
            r_rready <= 1'b0;
            r_rdata  <= m00_axi.rdata;
            r_rresp  <= m00_axi.rresp;
            r_cnt    <= '0;
            r_state  <= S_CHECK;
          end else begin
            r_cnt <= r_cnt + LP_CNT_W'(1);
          end
        end
        S_CHECK: begin
          r_cnt <= '0;
          if ((r_rresp != 2'b00) || (r_rdata != wordOf(r_cfg, r_idx))) begin
            error     <= 1'b1;
            err_code  <= 2'd2;
            err_index <= r_idx;
            done      <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_idx == 2'd3) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx     <= r_idx + 2'd1;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= addrOf(r_idx + 2'd1);
            r_wdata   <= wordOf(r_cfg, r_idx + 2'd1);
            r_state   <= S_WR;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_timeout) begin
        error     <= 1'b1;
        err_code  <= 2'd3;
        err_index <= r_idx;
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_bready  <= 1'b0;
        r_arvalid <= 1'b0;
        r_rready  <= 1'b0;
        r_cnt     <= '0;
        done      <= 1'b1;
        r_state   <= S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_threshold_cfg_master.sv
// ---------------------------------------------------------------------------
// tb_threshold_cfg_master
// Purpose : Directed bench for threshold_cfg_master. A behavioural AXI4-Lite
//           slave with switchable faults answers the master; stimulus pushes
//           expected writes, reads and final results into queues, and the
//           slave/monitor processes pop and compare as traffic appears.
// ---------------------------------------------------------------------------
module tb_threshold_cfg_master;

  localparam int          LP_TIMEOUT = 16;
  localparam logic [31:0] LP_BASE    = 32'h43C0_0000;

  typedef struct {
    logic       err;
    logic [1:0] idx;
    logic [1:0] code;
    int         maxLat;
    bit         toWindow;
  } result_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] cfgData = '0;
  logic         busy;
  logic         done;
  logic         error;
  logic [1:0]   errIndex;
  logic [1:0]   errCode;

  int checks = 0;
  int fails = 0;
  int cycleCount = 0;
  int startCycle = 0;
  int arRiseCycle = 0;

  result_t     expResQ[$];
  wr_t         expWrQ[$];
  logic [31:0] expRdQ[$];

  int bErrIdx = -1;
  int rBadIdx = -1;
  bit wDelay = 1'b0;
  bit arNever = 1'b0;
  bit holdB = 1'b0;

  threshold_cfg_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  threshold_cfg_master #(.C_TIMEOUT(LP_TIMEOUT)) dut (
    .m00_axi_aclk  (clk),
    .m00_axi_areset(rst),
    .start         (start),
    .cfg_data      (cfgData),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_index     (errIndex),
    .err_code      (errCode),
    .m00_axi       (axi)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurements.
  initial forever begin
    @(posedge clk);
    cycleCount++;
  end

  // One comparison: counts it, and reports it when the values differ.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  // Queues the expected traffic and result for one sequence, then pulses
  // start for a single cycle and notes the cycle in which it was sampled.
  task automatic applyStimulus(input logic [127:0] data, input bit pushRes,
                               input result_t res, input int nWr, input int nRd);
    wr_t w;
    for (int i = 0; i < nWr; i++) begin
      w.addr = LP_BASE + 32'(4 * i);
      w.data = data[32*i +: 32];
      expWrQ.push_back(w);
    end
    for (int i = 0; i < nRd; i++) expRdQ.push_back(LP_BASE + 32'(4 * i));
    if (pushRes) expResQ.push_back(res);
    @(negedge clk);
    cfgData = data;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    startCycle = cycleCount;
  endtask

  // Waits (bounded) for the monitor to consume the expected result, then
  // confirms all expected bus traffic was seen and the flags stay sticky.
  task automatic waitDone(input string name, input result_t res);
    int n = 0;
    while (expResQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " done seen"}, 32'(expResQ.size()), 32'd0);
    checkOutput({name, " writes consumed"}, 32'(expWrQ.size()), 32'd0);
    checkOutput({name, " reads consumed"}, 32'(expRdQ.size()), 32'd0);
    expResQ.delete();
    expWrQ.delete();
    expRdQ.delete();
    repeat (3) @(negedge clk);
    checkOutput({name, " busy idle"}, 32'(busy), 32'd0);
    checkOutput({name, " error sticky"}, 32'(error), 32'(res.err));
    checkOutput({name, " err_code sticky"}, 32'(errCode), 32'(res.code));
  endtask

  // Behavioural AXI4-Lite slave. It acts on the falling edge: handshakes
  // that happened at the preceding rising edge are recovered from the
  // valid/ready snapshot taken at the previous falling edge, since neither
  // side changes its outputs between a falling edge and the next rising one.
  initial begin : slave
    bit          haveA, haveW, logged;
    bit          sAw, sW, sB, sAr, sR;
    logic [31:0] pA, pW, sAwAddr, sWData, sArAddr, offs;
    logic [31:0] mem [4];
    int          wCnt, idx;
    wr_t         e;
    haveA = 0; haveW = 0; logged = 0;
    sAw = 0; sW = 0; sB = 0; sAr = 0; sR = 0;
    pA = '0; pW = '0; sAwAddr = '0; sWData = '0; sArAddr = '0; wCnt = 0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        haveA = 0; haveW = 0; logged = 0;
        sAw = 0; sW = 0; sB = 0; sAr = 0; sR = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rresp = 0;
        continue;
      end
      if (sB) axi.bvalid = 0;
      if (sR) axi.rvalid = 0;
      if (sAw) begin haveA = 1; pA = sAwAddr; wCnt = 0; end
      if (sW) begin haveW = 1; pW = sWData; end
      if (haveA && !haveW) wCnt++;
      offs = (pA - LP_BASE) >> 2;
      idx = int'(offs[1:0]);
      if (haveA && haveW && !logged) begin
        logged = 1;
        mem[idx] = pW;
        if (expWrQ.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL unexpected write: addr %0h data %0h", pA, pW);
        end else begin
          e = expWrQ.pop_front();
          checkOutput("write address", pA, e.addr);
          checkOutput("write data", pW, e.data);
        end
      end
      if (logged && !axi.bvalid && !holdB) begin
        axi.bvalid = 1;
        axi.bresp = (idx == bErrIdx) ? 2'b10 : 2'b00;
        haveA = 0; haveW = 0; logged = 0;
      end
      if (sAr) begin
        if (expRdQ.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL unexpected read: addr %0h", sArAddr);
        end else begin
          checkOutput("read address", sArAddr, expRdQ.pop_front());
        end
        offs = (sArAddr - LP_BASE) >> 2;
        axi.rvalid = 1;
        axi.rresp = 2'b00;
        axi.rdata = (int'(offs[1:0]) == rBadIdx) ? 32'habcd0000 : mem[offs[1:0]];
      end
      axi.awready = !haveA;
      axi.wready = wDelay ? (haveA && !haveW && wCnt >= 3) : !haveW;
      axi.arready = !arNever && !axi.rvalid;
      sAw = axi.awvalid && axi.awready; sAwAddr = axi.awaddr;
      sW  = axi.wvalid && axi.wready;   sWData  = axi.wdata;
      sB  = axi.bvalid && axi.bready;
      sAr = axi.arvalid && axi.arready; sArAddr = axi.araddr;
      sR  = axi.rvalid && axi.rready;
    end
  end

  // Monitor: checks channel discipline (valids held with stable payload
  // until accepted, dropped right after acceptance) and, on each done
  // pulse, pops the expected result and compares flags and latency.
  initial begin : monitor
    bit          pAwPend, pWPend, pArPend, pAwFire, pWFire, pArFire, prevAr;
    logic [31:0] pAwAddr, pWData, pArAddr;
    result_t     r;
    int          lat;
    pAwPend = 0; pWPend = 0; pArPend = 0;
    pAwFire = 0; pWFire = 0; pArFire = 0; prevAr = 0;
    pAwAddr = '0; pWData = '0; pArAddr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pAwPend = 0; pWPend = 0; pArPend = 0;
        pAwFire = 0; pWFire = 0; pArFire = 0; prevAr = 0;
        continue;
      end
      if (axi.arvalid && !prevAr) arRiseCycle = cycleCount;
      prevAr = axi.arvalid;
      if (!done) begin
        if (pAwPend) begin
          checkOutput("awvalid held", 32'(axi.awvalid), 32'd1);
          checkOutput("awaddr stable", axi.awaddr, pAwAddr);
        end
        if (pWPend) begin
          checkOutput("wvalid held", 32'(axi.wvalid), 32'd1);
          checkOutput("wdata stable", axi.wdata, pWData);
        end
        if (pArPend) begin
          checkOutput("arvalid held", 32'(axi.arvalid), 32'd1);
          checkOutput("araddr stable", axi.araddr, pArAddr);
        end
      end
      if (pAwFire) checkOutput("awvalid drop", 32'(axi.awvalid), 32'd0);
      if (pWFire) checkOutput("wvalid drop", 32'(axi.wvalid), 32'd0);
      if (pArFire) checkOutput("arvalid drop", 32'(axi.arvalid), 32'd0);
      if (done) begin
        if (expResQ.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL unexpected done: err %0d code %0d", error, errCode);
        end else begin
          r = expResQ.pop_front();
          lat = cycleCount - startCycle;
          checkOutput("error", 32'(error), 32'(r.err));
          checkOutput("err_index", 32'(errIndex), 32'(r.idx));
          checkOutput("err_code", 32'(errCode), 32'(r.code));
          checkOutput("busy at done", 32'(busy), 32'd1);
          checkOutput("valids low at done",
                      {29'd0, axi.awvalid, axi.wvalid, axi.arvalid}, 32'd0);
          checkOutput("latency within bound", 32'(lat <= r.maxLat), 32'd1);
          if (r.toWindow)
            checkOutput("timeout window 16..17",
                        32'((cycleCount - arRiseCycle) inside {16, 17}), 32'd1);
        end
      end
      pAwPend = axi.awvalid && !axi.awready; pAwAddr = axi.awaddr;
      pWPend  = axi.wvalid && !axi.wready;   pWData  = axi.wdata;
      pArPend = axi.arvalid && !axi.arready; pArAddr = axi.araddr;
      pAwFire = axi.awvalid && axi.awready;
      pWFire  = axi.wvalid && axi.wready;
      pArFire = axi.arvalid && axi.arready;
    end
  end

  // Every output that reset must force low.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " error"}, 32'(error), 32'd0);
    checkOutput({tag, " err_index"}, 32'(errIndex), 32'd0);
    checkOutput({tag, " err_code"}, 32'(errCode), 32'd0);
    checkOutput({tag, " valids/readies"},
                {27'd0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready},
                32'd0);
  endtask

  // Directed scenarios, each with hand-computed expectations.
  initial begin : stimulus
    logic [127:0] d0, d1, d2;
    result_t      rPass, rBresp, rData, rTo, rPassSlow;
    int           n;
    d0 = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF};
    d1 = {32'h7fffffff, 32'h80000000, 32'h00000001, 32'hffffffff};
    d2 = {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
    rPass     = '{1'b0, 2'd0, 2'd0, 22, 1'b0};
    rBresp    = '{1'b1, 2'd2, 2'd1, 22, 1'b0};
    rData     = '{1'b1, 2'd1, 2'd2, 22, 1'b0};
    rTo       = '{1'b1, 2'd0, 2'd3, 40, 1'b1};
    rPassSlow = '{1'b0, 2'd0, 2'd0, 40, 1'b0};

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] clean sequence");
    applyStimulus(d0, 1'b1, rPass, 4, 4);
    waitDone("clean", rPass);

    $display("[TB] BRESP error on index 2");
    bErrIdx = 2;
    applyStimulus(d0, 1'b1, rBresp, 3, 2);
    waitDone("bresp", rBresp);
    bErrIdx = -1;

    $display("[TB] read-back mismatch on index 1");
    rBadIdx = 1;
    applyStimulus(d0, 1'b1, rData, 2, 2);
    waitDone("rdata", rData);
    rBadIdx = -1;

    $display("[TB] delayed wready");
    wDelay = 1'b1;
    applyStimulus(d1, 1'b1, rPassSlow, 4, 4);
    waitDone("wdelay", rPassSlow);
    wDelay = 1'b0;

    $display("[TB] arready never asserted");
    arNever = 1'b1;
    applyStimulus(d0, 1'b1, rTo, 1, 0);
    waitDone("artimeout", rTo);
    arNever = 1'b0;

    $display("[TB] reset while waiting for write response");
    holdB = 1'b1;
    applyStimulus(d0, 1'b0, rPass, 1, 0);
    n = 0;
    while (!axi.bready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached WAIT_B", 32'(axi.bready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetOutputs("async reset");
    @(negedge clk);
    checkResetOutputs("held reset");
    rst = 1'b0;
    holdB = 1'b0;
    checkOutput("aborted write seen", 32'(expWrQ.size()), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("idle after reset busy", 32'(busy), 32'd0);
    checkOutput("idle after reset valids",
                {30'd0, axi.awvalid, axi.arvalid}, 32'd0);
    applyStimulus(d2, 1'b1, rPass, 4, 4);
    waitDone("post-reset", rPass);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
